// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg
//   EX->MEM pipeline boundary. Each ALU result packet from EX is held in a
//   2-entry skid buffer (MAIN = head, SKID = younger) and handed to MEM over
//   a valid/ready handshake. ex_ready is a flop, so MEM back-pressure never
//   reaches EX combinationally. The youngest held entry also drives the
//   EX->EX forwarding path. A saturating counter records the cycles in
//   which EX was blocked.
// Ports
//   clk, rst_n          clock, async active-low reset
//   flush               sync flush: drops both entries and any same-cycle capture
//   ex_valid/ex_ready   EX-side handshake (ex_ready registered)
//   ex_*                incoming packet payload
//   mem_valid/mem_ready MEM-side handshake; mem_* is the head payload
//   fwd_en/rd/data      forwarding value from the youngest valid entry
//   stall_cnt           saturating count of ex_valid && !ex_ready cycles
module ex_mem_skid_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic [XLEN-1:0]  ex_store_data,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [4:0]       ex_rd,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_overflow,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [XLEN-1:0]  mem_alu_result,
  output logic [XLEN-1:0]  mem_store_data,
  output logic [XLEN-1:0]  mem_pc,
  output logic [4:0]       mem_rd,
  output logic [2:0]       mem_funct3,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             mem_overflow,
  output logic             fwd_en,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            overflow;
  } pkt_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_e;

  state_e           state_q, state_d;
  pkt_t             main_q, main_d;
  pkt_t             skid_q, skid_d;
  logic             ex_ready_q;
  logic [CNT_W-1:0] stall_q, stall_d;

  pkt_t             in_pkt;
  pkt_t             young;
  logic             acc;
  logic             pop;

  // Writes to x0 are architecturally void; drop reg_write at capture so
  // neither MEM/WB nor the forwarding path ever see them.
  always_comb begin
    in_pkt.alu_result = ex_alu_result;
    in_pkt.store_data = ex_store_data;
    in_pkt.pc         = ex_pc;
    in_pkt.rd         = ex_rd;
    in_pkt.funct3     = ex_funct3;
    in_pkt.reg_write  = ex_reg_write && (ex_rd != 5'd0);
    in_pkt.mem_read   = ex_mem_read;
    in_pkt.mem_write  = ex_mem_write;
    in_pkt.overflow   = ex_overflow;
  end

  assign mem_valid = (state_q != S_EMPTY);
  assign ex_ready  = ex_ready_q;
  assign acc       = ex_valid && ex_ready_q;
  assign pop       = mem_valid && mem_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    unique case (state_q)
      S_EMPTY: begin
        if (acc) begin
          state_d = S_ONE;
          main_d  = in_pkt;
        end
      end
      S_ONE: begin
        if (acc && pop) begin
          main_d = in_pkt;
        end else if (acc) begin
          state_d = S_FULL;
          skid_d  = in_pkt;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // Flush wins over everything: any concurrent capture is discarded and
    // the payload registers are left untouched (only validity is cleared).
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    if (ex_valid && !ex_ready_q && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      ex_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      ex_ready_q <= (state_d != S_FULL);
      stall_q    <= stall_d;
    end
  end

  assign mem_alu_result = main_q.alu_result;
  assign mem_store_data = main_q.store_data;
  assign mem_pc         = main_q.pc;
  assign mem_rd         = main_q.rd;
  assign mem_funct3     = main_q.funct3;
  assign mem_reg_write  = main_q.reg_write;
  assign mem_mem_read   = main_q.mem_read;
  assign mem_mem_write  = main_q.mem_write;
  assign mem_overflow   = main_q.overflow;

  // Youngest result wins: when both entries are held, SKID is newer.
  // Loads never forward; their data is not known until MEM.
  assign young    = (state_q == S_FULL) ? skid_q : main_q;
  assign fwd_en   = mem_valid && young.reg_write && !young.mem_read && !flush;
  assign fwd_rd   = fwd_en ? young.rd : '0;
  assign fwd_data = fwd_en ? young.alu_result : '0;

  assign stall_cnt = stall_q;

endmodule
